// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared RAM opcodes and fetch-unit state encodings
package instruction_fetch_unit_pkg;

    // RAM opcode constants driven on RAM_OpCode
    localparam logic [5:0] LOAD_WORD_OP_C  = 6'b000000;
    localparam logic [5:0] LOAD_BYTE_OP_C  = 6'b000001;
    localparam logic [5:0] LOAD_HALF_OP_C  = 6'b000010;
    localparam logic [5:0] STORE_WORD_OP_C = 6'b000100;
    localparam logic [5:0] STORE_BYTE_OP_C = 6'b000101;
    localparam logic [5:0] STORE_HALF_OP_C = 6'b000110;

    // Fetch-unit FSM states
    typedef enum logic [2:0] {
        IFU_IDLE     = 3'd0,
        IFU_ISSUE    = 3'd1,
        IFU_WAIT_MFC = 3'd2,
        IFU_DELIVER  = 3'd3,
        IFU_FAULT    = 3'd4
    } ifu_state_e;

    // True for any RAM read opcode
    function automatic logic is_load_op(input logic [5:0] op);
        return (op == LOAD_WORD_OP_C) || (op == LOAD_BYTE_OP_C) || (op == LOAD_HALF_OP_C);
    endfunction

    // True for any RAM write opcode
    function automatic logic is_store_op(input logic [5:0] op);
        return (op == STORE_WORD_OP_C) || (op == STORE_BYTE_OP_C) || (op == STORE_HALF_OP_C);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// rtl/instruction_fetch_unit_timeout_counter.sv - saturating MFC wait counter with terminal-count flag
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX_VAL = {CW{1'b1}};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over enable; counting stops at all-ones so it can never wrap back below terminal count
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MAX_VAL)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q >= TC_VAL);

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetches the word at PC from RAM and loads it into IR
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [5:0] LOAD_WORD_OP   = LOAD_WORD_OP_C,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        fetch_req,
    input  logic        flush,
    input  logic [31:0] PC_in,
    output logic        RAM_enable,
    output logic [5:0]  RAM_OpCode,
    output logic [31:0] RAM_address,
    input  logic [31:0] RAM_data_in,
    input  logic        MFC,
    output logic [31:0] IR_In,
    output logic        IR_Enable,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    ifu_state_e  state_q, state_d;
    logic        ram_enable_d, ir_enable_d, busy_d, fault_d;
    logic [5:0]  ram_opcode_d;
    logic        timeout_tc;
    logic        capture_pc;
    logic        capture_ir;

    // PC is taken only when an idle unit accepts a request; IR only on a clean MFC
    assign capture_pc = (state_q == IFU_IDLE) && fetch_req;
    assign capture_ir = (state_q == IFU_WAIT_MFC) && MFC && !flush;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (Clk),
        .rst_i   (RESET),
        .clear_i (state_q == IFU_ISSUE),
        .enable_i(state_q == IFU_WAIT_MFC),
        .tc_o    (timeout_tc)
    );

    // State, captured address/data and registered outputs
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q     <= IFU_IDLE;
            RAM_address <= '0;
            IR_In       <= '0;
            RAM_enable  <= 1'b0;
            RAM_OpCode  <= '0;
            IR_Enable   <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (capture_pc) RAM_address <= PC_in;
            if (capture_ir) IR_In <= RAM_data_in;
            RAM_enable  <= ram_enable_d;
            RAM_OpCode  <= ram_opcode_d;
            IR_Enable   <= ir_enable_d;
            fetch_busy  <= busy_d;
            fetch_fault <= fault_d;
        end
    end

    // Next-state: flush beats MFC, MFC beats timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: begin
                if (fetch_req) begin
                    state_d = (PC_in[1:0] != 2'b00) ? IFU_FAULT : IFU_ISSUE;
                end
            end
            IFU_ISSUE: begin
                state_d = flush ? IFU_IDLE : IFU_WAIT_MFC;
            end
            IFU_WAIT_MFC: begin
                if (flush) begin
                    state_d = IFU_IDLE;
                end else if (MFC) begin
                    state_d = IFU_DELIVER;
                end else if (timeout_tc) begin
                    state_d = IFU_FAULT;
                end
            end
            IFU_DELIVER: state_d = IFU_IDLE;
            IFU_FAULT:   state_d = IFU_IDLE;
            default:     state_d = IFU_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_comb begin
        ram_enable_d = (state_d == IFU_ISSUE) || (state_d == IFU_WAIT_MFC);
        ram_opcode_d = ram_enable_d ? LOAD_WORD_OP : 6'b000000;
        ir_enable_d  = (state_d == IFU_DELIVER);
        fault_d      = (state_d == IFU_FAULT);
        busy_d       = (state_d != IFU_IDLE);
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] PC_in = '0;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] RAM_address;
    logic [31:0] RAM_data_in = '0;
    logic        MFC = 1'b0;
    logic [31:0] IR_In;
    logic        IR_Enable;
    logic        fetch_busy;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;
    int ren_cnt;
    int busy_cnt;

    instruction_fetch_unit #(
        .LOAD_WORD_OP  (6'b000000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk        (Clk),
        .RESET      (RESET),
        .fetch_req  (fetch_req),
        .flush      (flush),
        .PC_in      (PC_in),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .RAM_address(RAM_address),
        .RAM_data_in(RAM_data_in),
        .MFC        (MFC),
        .IR_In      (IR_In),
        .IR_Enable  (IR_Enable),
        .fetch_busy (fetch_busy),
        .fetch_fault(fetch_fault)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic ren, input logic ire,
                           input logic busy, input logic flt);
        chk({tag, " RAM_enable"}, 32'(RAM_enable), 32'(ren));
        chk({tag, " IR_Enable"},  32'(IR_Enable),  32'(ire));
        chk({tag, " fetch_busy"}, 32'(fetch_busy), 32'(busy));
        chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'(flt));
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk_ctl("reset", 0, 0, 0, 0);
        chk("reset IR_In", IR_In, 32'h0);
        chk("reset RAM_address", RAM_address, 32'h0);
        chk("reset RAM_OpCode", 32'(RAM_OpCode), 32'h0);
        RESET = 1'b0;
        tick();
        chk_ctl("post-reset idle", 0, 0, 0, 0);

        // Zero-wait fetch at PC 0
        PC_in = 32'h0; RAM_data_in = 32'h8200_2003; fetch_req = 1'b1;
        busy_cnt = 0;
        tick();                                   // ISSUE
        fetch_req = 1'b0;
        chk_ctl("zw issue", 1, 0, 1, 0);
        chk("zw opcode", 32'(RAM_OpCode), 32'h0);
        busy_cnt += int'(fetch_busy);
        tick();                                   // WAIT_MFC
        MFC = 1'b1;
        chk_ctl("zw wait", 1, 0, 1, 0);
        busy_cnt += int'(fetch_busy);
        tick();                                   // DELIVER at req+3
        MFC = 1'b0;
        chk_ctl("zw deliver", 0, 1, 1, 0);
        chk("zw IR_In", IR_In, 32'h8200_2003);
        busy_cnt += int'(fetch_busy);
        tick();                                   // IDLE
        chk_ctl("zw idle", 0, 0, 0, 0);
        chk("zw busy cycles", 32'(busy_cnt), 32'd3);
        chk("zw IR_In held", IR_In, 32'h8200_2003);

        // Wait states: MFC in the fifth WAIT cycle, busy request ignored
        PC_in = 32'h100; RAM_data_in = 32'hC420_2020; fetch_req = 1'b1;
        tick();                                   // ISSUE
        fetch_req = 1'b0;
        ren_cnt = int'(RAM_enable);
        for (int i = 1; i <= 5; i++) begin
            tick();                               // WAIT i
            ren_cnt += int'(RAM_enable);
            chk($sformatf("ws wait%0d IR_Enable", i), 32'(IR_Enable), 32'h0);
            chk($sformatf("ws wait%0d address", i), RAM_address, 32'h100);
            chk($sformatf("ws wait%0d IR_In", i), IR_In, 32'h8200_2003);
            fetch_req = (i == 1 || i == 2);
            PC_in     = (i == 1 || i == 2) ? 32'h200 : 32'h100;
            MFC       = (i == 5);
        end
        tick();                                   // DELIVER
        MFC = 1'b0;
        ren_cnt += int'(RAM_enable);
        chk_ctl("ws deliver", 0, 1, 1, 0);
        chk("ws IR_In", IR_In, 32'hC420_2020);
        chk("ws RAM_enable cycles", 32'(ren_cnt), 32'd6);
        chk("ws address held", RAM_address, 32'h100);
        tick();
        chk_ctl("ws idle", 0, 0, 0, 0);

        // Misaligned PC
        PC_in = 32'h0000_0022; fetch_req = 1'b1;
        tick();                                   // FAULT at req+1
        fetch_req = 1'b0;
        chk_ctl("mis fault", 0, 0, 1, 1);
        chk("mis IR_In", IR_In, 32'hC420_2020);
        tick();
        chk_ctl("mis idle", 0, 0, 0, 0);

        // Timeout: 16 WAIT cycles without MFC
        PC_in = 32'h40; fetch_req = 1'b1;
        tick();                                   // ISSUE
        fetch_req = 1'b0;
        ren_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            ren_cnt += int'(RAM_enable);
            chk($sformatf("to wait%0d fault", i), 32'(fetch_fault), 32'h0);
        end
        chk("to wait enable cycles", 32'(ren_cnt), 32'd16);
        tick();
        chk_ctl("to fault", 0, 0, 1, 1);
        chk("to IR_In", IR_In, 32'hC420_2020);
        tick();
        chk_ctl("to idle", 0, 0, 0, 0);
        tick();
        chk_ctl("to idle2", 0, 0, 0, 0);

        // Flush in ISSUE
        PC_in = 32'h8; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_ctl("fl issue", 0, 0, 0, 0);

        // Flush colliding with MFC in WAIT_MFC, then stale MFC in IDLE
        PC_in = 32'h80; RAM_data_in = 32'hDEAD_BEEF; fetch_req = 1'b1;
        tick();                                   // ISSUE
        fetch_req = 1'b0;
        tick();                                   // WAIT
        flush = 1'b1; MFC = 1'b1;
        tick();
        flush = 1'b0;
        chk_ctl("fc abort", 0, 0, 0, 0);
        chk("fc IR_In", IR_In, 32'hC420_2020);
        tick();                                   // stale MFC still high in IDLE
        MFC = 1'b0;
        chk_ctl("fc stale", 0, 0, 0, 0);
        chk("fc stale IR_In", IR_In, 32'hC420_2020);

        // Following fetch at PC 4 succeeds
        PC_in = 32'h4; RAM_data_in = 32'h1122_3344; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("fc2 address", RAM_address, 32'h4);
        tick();
        MFC = 1'b1;
        tick();
        MFC = 1'b0;
        chk_ctl("fc2 deliver", 0, 1, 1, 0);
        chk("fc2 IR_In", IR_In, 32'h1122_3344);
        tick();

        // Reset in WAIT_MFC
        PC_in = 32'hC; RAM_data_in = 32'h5555_AAAA; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        chk("rst pre RAM_enable", 32'(RAM_enable), 32'h1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_ctl("rst mid", 0, 0, 0, 0);
        chk("rst IR_In", IR_In, 32'h0);
        chk("rst address", RAM_address, 32'h0);
        MFC = 1'b1;
        tick();
        MFC = 1'b0;
        chk_ctl("rst late MFC", 0, 0, 0, 0);
        chk("rst late IR_In", IR_In, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
